// File: rtl/sram_controller_pkg.sv
`default_nettype none
// ============================================================================
// Module : sram_controller_pkg
// Brief  : State encoding and SRAM control-pin constants for sram_controller.
// Rev    : 1.0
// ============================================================================
package sram_controller_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOW  = 2'd1,
        HIGH = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam int WE_N = 4;
    localparam int OE_N = 3;
    localparam int CE_N = 2;
    localparam int UB_N = 1;
    localparam int LB_N = 0;

    localparam logic [4:0] CTRL_IDLE = 5'b11111;

    // Both byte lanes and the chip are always enabled during a half-word phase.
    function automatic logic [4:0] active_ctrl(input logic is_write);
        logic [4:0] ctrl;
        ctrl       = 5'b00000;
        ctrl[WE_N] = ~is_write;
        ctrl[OE_N] = is_write;
        return ctrl;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sram_controller_if.sv
`default_nettype none
// ============================================================================
// Module : sram_controller_if
// Brief  : MEM-stage word load/store request bus toward the SRAM controller.
// Rev    : 1.0
// ============================================================================
interface sram_controller_if;

    logic        wrEn;
    logic        rdEn;
    logic [31:0] address;
    logic [31:0] writeData;
    logic [31:0] readData;
    logic        ready;

    modport master (
        output wrEn,
        output rdEn,
        output address,
        output writeData,
        input  readData,
        input  ready
    );

    modport slave (
        input  wrEn,
        input  rdEn,
        input  address,
        input  writeData,
        output readData,
        output ready
    );

endinterface
`default_nettype wire

// File: rtl/sram_controller.sv
`default_nettype none
// ============================================================================
// Module : sram_controller
// Brief  : Splits 32-bit word accesses into two 16-bit async SRAM cycles.
// Rev    : 1.0
// ============================================================================
module sram_controller
    import sram_controller_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR     = 32'd1024,
    parameter int unsigned ACCESS_CYCLES = 2
) (
    input  wire logic        clk,
    input  wire logic        rst,
    sram_controller_if.slave mem,
    inout  wire [15:0]       sramData,
    output logic [17:0]      sramAddress,
    output logic [4:0]       sramCtrl
);

    localparam logic [3:0] c_last_phase = 4'(ACCESS_CYCLES - 1);

    state_t      r_state;
    logic [3:0]  r_cnt;
    logic        r_is_write;
    logic [16:0] r_word;
    logic [15:0] r_wdata_hi;
    logic [31:0] r_read_data;
    logic [17:0] r_sram_addr;
    logic [4:0]  r_sram_ctrl;
    logic        r_drive;
    logic [15:0] r_bus_out;

    logic        w_req;
    logic        w_last;
    logic [16:0] w_word;

    assign w_req  = mem.wrEn | mem.rdEn;
    assign w_last = (r_cnt == c_last_phase);
    // 32-bit subtract, then truncate: out-of-range addresses wrap silently.
    assign w_word = 17'((mem.address - BASE_ADDR) >> 2);

    assign mem.ready    = ((r_state == IDLE) && !w_req) || (r_state == DONE);
    assign mem.readData = r_read_data;
    assign sramAddress  = r_sram_addr;
    assign sramCtrl     = r_sram_ctrl;
    assign sramData     = r_drive ? r_bus_out : 16'bz;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_cnt       <= 4'd0;
            r_is_write  <= 1'b0;
            r_word      <= 17'd0;
            r_wdata_hi  <= 16'd0;
            r_read_data <= 32'd0;
            r_sram_addr <= 18'd0;
            r_sram_ctrl <= CTRL_IDLE;
            r_drive     <= 1'b0;
            r_bus_out   <= 16'd0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_req) begin
                        // A simultaneous wrEn/rdEn resolves to a write.
                        r_is_write  <= mem.wrEn;
                        r_word      <= w_word;
                        r_wdata_hi  <= mem.writeData[31:16];
                        r_cnt       <= 4'd0;
                        r_sram_addr <= {w_word, 1'b0};
                        r_sram_ctrl <= active_ctrl(mem.wrEn);
                        r_drive     <= mem.wrEn;
                        r_bus_out   <= mem.writeData[15:0];
                        r_state     <= LOW;
                    end
                end
                LOW: begin
                    if (w_last) begin
                        if (!r_is_write) begin
                            r_read_data[15:0] <= sramData;
                        end
                        r_cnt       <= 4'd0;
                        r_sram_addr <= {r_word, 1'b1};
                        r_bus_out   <= r_wdata_hi;
                        r_state     <= HIGH;
                    end else begin
                        r_cnt <= r_cnt + 4'd1;
                    end
                end
                HIGH: begin
                    if (w_last) begin
                        if (!r_is_write) begin
                            r_read_data[31:16] <= sramData;
                        end
                        r_cnt       <= 4'd0;
                        r_sram_ctrl <= CTRL_IDLE;
                        r_drive     <= 1'b0;
                        r_state     <= DONE;
                    end else begin
                        r_cnt <= r_cnt + 4'd1;
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sram_controller.sv
`default_nettype none
// ============================================================================
// Module : tb_sram_controller
// Brief  : Directed scoreboard bench for sram_controller with an async SRAM model.
// Rev    : 1.0
// ============================================================================
module tb_sram_controller;
    import sram_controller_pkg::*;

    localparam int          AC        = 2;
    localparam logic [15:0] KEEP      = 16'hA5C3;
    localparam logic [4:0]  CTRL_WR   = 5'b01000;
    localparam logic [4:0]  CTRL_RD   = 5'b10000;

    typedef struct packed {
        logic [17:0] addr;
        logic [4:0]  ctrl;
        logic [15:0] data;
        logic        dchk;
    } exp_t;

    logic        clk;
    logic        rst;
    wire  [15:0] sram_data;
    logic [17:0] sram_addr;
    logic [4:0]  sram_ctrl;

    int          checks;
    int          errors;
    int          busy;
    logic [31:0] last_read;
    exp_t        exp_q[$];
    logic [31:0] rd_q[$];

    sram_controller_if bus();

    sram_controller #(
        .BASE_ADDR    (32'd1024),
        .ACCESS_CYCLES(AC)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .mem        (bus),
        .sramData   (sram_data),
        .sramAddress(sram_addr),
        .sramCtrl   (sram_ctrl)
    );

    // SRAM model: drives stored data on reads, a keeper pattern when the bus should be free.
    logic [15:0] mem_arr [0:1023];
    logic        tb_en;
    logic [15:0] tb_drv;

    always_comb begin
        tb_en  = 1'b0;
        tb_drv = 16'h0000;
        if (!sram_ctrl[CE_N] && !sram_ctrl[OE_N]) begin
            tb_en  = 1'b1;
            tb_drv = mem_arr[sram_addr[9:0]];
        end else if (sram_ctrl[WE_N]) begin
            tb_en  = 1'b1;
            tb_drv = KEEP;
        end
    end

    assign sram_data = tb_en ? tb_drv : 16'hzzzz;

    always @(posedge clk) begin
        if (!sram_ctrl[WE_N] && !sram_ctrl[CE_N]) begin
            mem_arr[sram_addr[9:0]] <= sram_data;
        end
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
        end
    endtask

    task automatic idle(input int n);
        bus.wrEn = 1'b0;
        bus.rdEn = 1'b0;
        repeat (n) begin
            @(negedge clk);
            check("idle_ready", 32'(bus.ready), 32'd1);
            check("idle_ctrl", 32'(sram_ctrl), 32'(CTRL_IDLE));
            check("idle_bus", 32'(sram_data), 32'(KEEP));
        end
    endtask

    // Called at a negedge; b2b means the current cycle is the previous request's DONE.
    task automatic run_req(input logic wr, input logic rd, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [16:0] word,
                           input logic [31:0] rexp, input logic b2b, input logic drop);
        exp_t e;
        int   n;
        for (int ph = 0; ph < 2; ph++) begin
            for (int k = 0; k < AC; k++) begin
                e.addr = {word, 1'(ph)};
                e.ctrl = wr ? CTRL_WR : CTRL_RD;
                e.data = (ph == 0) ? wdata[15:0] : wdata[31:16];
                e.dchk = wr;
                exp_q.push_back(e);
            end
        end
        rd_q.push_back(wr ? last_read : rexp);
        if (!wr) last_read = rexp;

        bus.wrEn      = wr;
        bus.rdEn      = rd;
        bus.address   = addr;
        bus.writeData = wdata;
        if (b2b) @(negedge clk);
        #1;
        check("cycle0_ready", 32'(bus.ready), 32'd0);
        if (bus.ready === 1'b0) busy++;

        n = 0;
        while (exp_q.size() > 0) begin
            @(negedge clk);
            e = exp_q.pop_front();
            n++;
            check("phase_addr", 32'(sram_addr), 32'(e.addr));
            check("phase_ctrl", 32'(sram_ctrl), 32'(e.ctrl));
            check("phase_ready", 32'(bus.ready), 32'd0);
            if (bus.ready === 1'b0) busy++;
            if (e.dchk) check("phase_wdata", 32'(sram_data), 32'(e.data));
            if (drop && n == 1) begin
                bus.wrEn = 1'b0;
                bus.rdEn = 1'b0;
            end
        end

        @(negedge clk);
        check("done_ready", 32'(bus.ready), 32'd1);
        check("done_ctrl", 32'(sram_ctrl), 32'(CTRL_IDLE));
        check("done_bus", 32'(sram_data), 32'(KEEP));
        check("done_rdata", bus.readData, rd_q.pop_front());
    endtask

    initial begin
        checks        = 0;
        errors        = 0;
        busy          = 0;
        last_read     = 32'd0;
        bus.wrEn      = 1'b0;
        bus.rdEn      = 1'b0;
        bus.address   = 32'd0;
        bus.writeData = 32'd0;
        rst           = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_rdata", bus.readData, 32'd0);
        check("rst_addr", 32'(sram_addr), 32'd0);
        check("rst_ctrl", 32'(sram_ctrl), 32'(CTRL_IDLE));
        check("rst_ready", 32'(bus.ready), 32'd1);
        check("rst_bus", 32'(sram_data), 32'(KEEP));
        rst = 1'b0;

        idle(3);
        run_req(1'b1, 1'b0, 32'd1024, 32'hDEADBEEF, 17'd0, 32'd0, 1'b0, 1'b0);
        idle(1);
        run_req(1'b0, 1'b1, 32'd1024, 32'd0, 17'd0, 32'hDEADBEEF, 1'b0, 1'b0);
        idle(1);
        run_req(1'b1, 1'b0, 32'd1031, 32'h12345678, 17'd1, 32'd0, 1'b0, 1'b0);
        idle(1);

        busy = 0;
        run_req(1'b1, 1'b0, 32'd1024, 32'hCAFEF00D, 17'd0, 32'd0, 1'b0, 1'b0);
        run_req(1'b0, 1'b1, 32'd1028, 32'd0, 17'd1, 32'h12345678, 1'b1, 1'b0);
        check("b2b_busy_cycles", 32'(busy), 32'd10);
        idle(1);

        run_req(1'b1, 1'b0, 32'd0, 32'hA5A55A5A, 17'h1FF00, 32'd0, 1'b0, 1'b1);
        idle(1);
        run_req(1'b0, 1'b1, 32'd0, 32'd0, 17'h1FF00, 32'hA5A55A5A, 1'b0, 1'b0);
        idle(1);

        run_req(1'b1, 1'b1, 32'd1024, 32'h0BADF00D, 17'd0, 32'd0, 1'b0, 1'b0);
        idle(1);
        run_req(1'b0, 1'b1, 32'd1024, 32'd0, 17'd0, 32'h0BADF00D, 1'b0, 1'b0);
        idle(1);

        // Reset asserted while a read sits in its high phase.
        bus.rdEn    = 1'b1;
        bus.address = 32'd1024;
        repeat (3) @(negedge clk);
        check("pre_rst_addr", 32'(sram_addr), 32'd1);
        check("pre_rst_ctrl", 32'(sram_ctrl), 32'(CTRL_RD));
        rst      = 1'b1;
        bus.rdEn = 1'b0;
        #1;
        check("midrst_ctrl", 32'(sram_ctrl), 32'(CTRL_IDLE));
        check("midrst_rdata", bus.readData, 32'd0);
        check("midrst_ready", 32'(bus.ready), 32'd1);
        check("midrst_bus", 32'(sram_data), 32'(KEEP));
        @(negedge clk);
        rst       = 1'b0;
        last_read = 32'd0;
        idle(1);
        run_req(1'b0, 1'b1, 32'd1031, 32'd0, 17'd1, 32'h12345678, 1'b0, 1'b0);
        idle(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
